// File: rtl/toom3_clmul_scheduler.sv
// Sequencer for a 3x3-limb carry-less 3W x 3W multiply on one shared W x W clmul core.
// Optional macro TOOM3_SKIP_ZERO_LIMB_EN: products with an all-zero limb are skipped without using the core.
module toom3_clmul_scheduler #(
    parameter int W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3*W-1:0]   a,
    input  logic [3*W-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [6*W-1:0]   c,
    output logic             core_start,
    output logic [W-1:0]     core_x,
    output logic [W-1:0]     core_y,
    input  logic             core_done,
    input  logic [2*W-1:0]   core_p,
    output logic [1:0]       dbg_state
);

`ifdef TOOM3_SKIP_ZERO_LIMB_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    // Core handshake: core_start is a one-cycle pulse; core_x/core_y stay stable
    // until the core answers with a one-cycle core_done carrying core_p (latency >= 1).
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state;
    logic [3*W-1:0]     a_q, b_q;
    logic [6*W-1:0]     acc;
    logic [3:0]         k;

    logic [3*W-1:0]     src_a, src_b;
    logic [3:0]         nk;
    logic [W-1:0]       nx, ny;
    logic               nskip;
    logic               cur_skip;
    logic [2:0]         sh;
    logic [6*W-1:0]     acc_next;
    logic               last;

    function automatic logic [1:0] idx_i(input logic [3:0] kk);
        if (kk >= 4'd6)      return 2'd2;
        else if (kk >= 4'd3) return 2'd1;
        else                 return 2'd0;
    endfunction

    function automatic logic [1:0] idx_j(input logic [3:0] kk);
        logic [3:0] r;
        r = kk - 4'd3 * {2'b00, idx_i(kk)};
        return r[1:0];
    endfunction

    function automatic logic [W-1:0] limb(input logic [3*W-1:0] v, input logic [1:0] sel);
        case (sel)
            2'd1:    return v[W +: W];
            2'd2:    return v[2*W +: W];
            default: return v[0 +: W];
        endcase
    endfunction

    // Operands for the next product; from IDLE they come straight from the inputs
    // because the latched copies are written on the same edge.
    always_comb begin
        src_a    = (state == IDLE) ? a : a_q;
        src_b    = (state == IDLE) ? b : b_q;
        nk       = (state == IDLE) ? 4'd0 : k + 4'd1;
        nx       = limb(src_a, idx_i(nk));
        ny       = limb(src_b, idx_j(nk));
        nskip    = SKIP_EN && ((nx == '0) || (ny == '0));
        cur_skip = SKIP_EN && ((core_x == '0) || (core_y == '0));
        sh       = {1'b0, idx_i(k)} + {1'b0, idx_j(k)};
        acc_next = acc ^ ({{(4*W){1'b0}}, core_p} << (W * sh));
        last     = (k == 4'd8);
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_start <= 1'b0;
            core_x     <= '0;
            core_y     <= '0;
            c          <= '0;
            acc        <= '0;
            k          <= '0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            core_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc        <= '0;
                        k          <= 4'd0;
                        core_x     <= nx;
                        core_y     <= ny;
                        core_start <= !nskip;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_skip) begin
                        if (last) begin
                            c     <= acc;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            k          <= nk;
                            core_x     <= nx;
                            core_y     <= ny;
                            core_start <= !nskip;
                            state      <= ISSUE;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        acc <= acc_next;
                        if (last) begin
                            c     <= acc_next;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            k          <= nk;
                            core_x     <= nx;
                            core_y     <= ny;
                            core_start <= !nskip;
                            state      <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toom3_clmul_scheduler.sv
// Bench for toom3_clmul_scheduler: vector table, random jobs against a bit-level clmul reference, reset abort.
module tb_toom3_clmul_scheduler;
    localparam int W = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3*W-1:0]   a_in = '0, b_in = '0;
    logic             busy, done;
    logic [6*W-1:0]   c;
    logic             core_start;
    logic [W-1:0]     core_x, core_y;
    logic             core_done = 1'b0;
    logic [2*W-1:0]   core_p = '0;
    logic [1:0]       dbg_state;

    int checks = 0;
    int failures = 0;

    int lat_cur = 1;
    int core_starts = 0;

    toom3_clmul_scheduler #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in),
        .busy(busy), .done(done), .c(c),
        .core_start(core_start), .core_x(core_x), .core_y(core_y),
        .core_done(core_done), .core_p(core_p), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] core_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            if (x[i]) r ^= {{W{1'b0}}, y} << i;
        return r;
    endfunction

    function automatic logic [6*W-1:0] ref_clmul(input logic [3*W-1:0] x, input logic [3*W-1:0] y);
        logic [6*W-1:0] r;
        r = '0;
        for (int i = 0; i < 3*W; i++)
            if (x[i]) r ^= {{(3*W){1'b0}}, y} << i;
        return r;
    endfunction

    function automatic int exp_issued(input logic [3*W-1:0] x, input logic [3*W-1:0] y);
`ifdef TOOM3_SKIP_ZERO_LIMB_EN
        int n;
        n = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if ((x[W*i +: W] != '0) && (y[W*j +: W] != '0)) n++;
        return n;
`else
        return 9;
`endif
    endfunction

    function automatic logic [3*W-1:0] rand192();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Behavioural core: answers each core_start with the product exactly lat_cur cycles later.
    initial begin
        logic [2*W-1:0] prod;
        int cnt;
        bit pend;
        pend = 0;
        cnt = 0;
        prod = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            core_p = {1'b0, $urandom(), $urandom(), $urandom(), $urandom()} ;
            core_p[2*W-1] = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_p = prod;
                    pend = 0;
                end
            end
            if (core_start) begin
                pend = 1;
                cnt = lat_cur;
                prod = core_mul(core_x, core_y);
                core_starts++;
            end
        end
    end

    task automatic check_vec(input string name, input logic [6*W-1:0] act, input logic [6*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input logic [3*W-1:0] av, input logic [3*W-1:0] bv, input int lat,
                           input bit hold, output logic [6*W-1:0] got_c, output int cyc,
                           output int starts, output bit busy_ok, output bit held_ok,
                           output bit post_ok, output bit got_done);
        logic [6*W-1:0] prev_c;
        @(posedge clk);
        #1;
        prev_c = c;
        core_starts = 0;
        lat_cur = lat;
        a_in = av;
        b_in = bv;
        start = 1'b1;
        cyc = 0;
        busy_ok = 1;
        held_ok = 1;
        got_done = 0;
        while (!got_done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hold) start = 1'b0;
            a_in = rand192();
            b_in = rand192();
            if (!busy) busy_ok = 0;
            if (done) got_done = 1;
            else if (c !== prev_c) held_ok = 0;
        end
        start = 1'b0;
        got_c = c;
        starts = core_starts;
        @(posedge clk);
        #1;
        post_ok = !done && !busy;
    endtask

    task automatic job_and_check(input string name, input logic [3*W-1:0] av, input logic [3*W-1:0] bv,
                                 input int lat, input bit hold, input logic [6*W-1:0] exp_c);
        logic [6*W-1:0] got_c;
        int cyc, starts, n;
        bit busy_ok, held_ok, post_ok, got_done;
        run_job(av, bv, lat, hold, got_c, cyc, starts, busy_ok, held_ok, post_ok, got_done);
        n = exp_issued(av, bv);
        check_int({name, " done_seen"}, int'(got_done), 1);
        check_vec({name, " c"}, got_c, exp_c);
        check_int({name, " latency"}, cyc, n * (lat + 1) + (9 - n) + 1);
        check_int({name, " core_starts"}, starts, n);
        check_int({name, " busy_during"}, int'(busy_ok), 1);
        check_int({name, " c_held"}, int'(held_ok), 1);
        check_int({name, " after_done"}, int'(post_ok), 1);
    endtask

    typedef struct {
        logic [3*W-1:0] a;
        logic [3*W-1:0] b;
        int             lat;
        logic [6*W-1:0] exp_c;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [3*W-1:0] one3, ones3, ra, rb;
        logic [6*W-1:0] one6;
        int lat, viol;

        one3 = 1;
        one6 = 1;
        ones3 = '1;
        vecs[0] = '{a: one3, b: one3, lat: 65, exp_c: one6};
        vecs[1] = '{a: ones3, b: one3, lat: 5, exp_c: {{(3*W){1'b0}}, ones3}};
        vecs[2] = '{a: one3 << 128, b: one3 << 128, lat: 3, exp_c: one6 << 256};
        vecs[3] = '{a: one3 << 191, b: one3 << 191, lat: 4, exp_c: one6 << 382};
        vecs[4] = '{a: '0, b: ones3, lat: 2, exp_c: '0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset busy", int'(busy), 0);
        check_int("reset done", int'(done), 0);
        check_int("reset core_start", int'(core_start), 0);
        check_vec("reset c", c, '0);
        check_vec("reset core_xy", {{(4*W){1'b0}}, core_x, core_y}, '0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++)
            job_and_check($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].lat, 1'b0, vecs[v].exp_c);

        for (int n = 0; n < 150; n++) begin
            ra = rand192();
            rb = rand192();
            if (n % 25 == 7) ra[W +: W] = '0;
            lat = (n % 10 == 0) ? $urandom_range(70, 1) : $urandom_range(6, 1);
            job_and_check($sformatf("rand%0d", n), ra, rb, lat, (n % 4 == 0), ref_clmul(ra, rb));
        end

        // Abort in WAIT of product k=4, then let the stale core_done arrive while idle.
        @(posedge clk);
        #1;
        core_starts = 0;
        lat_cur = 20;
        a_in = rand192();
        b_in = rand192();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        viol = 0;
        while (core_starts < 5 && viol < 2000) begin
            @(posedge clk);
            #1;
            viol++;
        end
        check_int("abort reached k4", core_starts, 5);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_int("abort busy", int'(busy), 0);
        check_int("abort done", int'(done), 0);
        check_int("abort core_start", int'(core_start), 0);
        check_vec("abort c", c, '0);
        viol = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy || core_start) viol++;
        end
        check_int("abort stays idle", viol, 0);
        ra = rand192();
        rb = rand192();
        job_and_check("after_abort", ra, rb, 7, 1'b0, ref_clmul(ra, rb));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
